// File: rtl/common_pkg.sv
// Shared Wishbone address map, target encoding and decode helpers for the 20-bit system bus.
package common_pkg;

    typedef enum logic [2:0] {
        WB_TGT_RAM,
        WB_TGT_REG,
        WB_TGT_CRTC,
        WB_TGT_KBD,
        WB_TGT_NONE
    } wb_target_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } wb_state_t;

    localparam int WB_TARGET_COUNT = 4;

    // RAM (incl. VRAM/VROM) and KBD span two 64 KiB pages; REG and CRTC one page each.
    localparam logic [19:0] WB_RAM_BASE  = 20'h00000;
    localparam logic [19:0] WB_RAM_MASK  = 20'hE0000;
    localparam logic [19:0] WB_REG_BASE  = 20'h40000;
    localparam logic [19:0] WB_REG_MASK  = 20'hF0000;
    localparam logic [19:0] WB_CRTC_BASE = 20'h50000;
    localparam logic [19:0] WB_CRTC_MASK = 20'hF0000;
    localparam logic [19:0] WB_KBD_BASE  = 20'h60000;
    localparam logic [19:0] WB_KBD_MASK  = 20'hE0000;

    function automatic wb_target_t wb_decode(input logic [19:0] addr);
        if ((addr & WB_RAM_MASK) == WB_RAM_BASE)   return WB_TGT_RAM;
        if ((addr & WB_REG_MASK) == WB_REG_BASE)   return WB_TGT_REG;
        if ((addr & WB_CRTC_MASK) == WB_CRTC_BASE) return WB_TGT_CRTC;
        if ((addr & WB_KBD_MASK) == WB_KBD_BASE)   return WB_TGT_KBD;
        return WB_TGT_NONE;
    endfunction

    function automatic logic [WB_TARGET_COUNT-1:0] wb_onehot(input wb_target_t tgt);
        logic [WB_TARGET_COUNT-1:0] oh;
        oh = '0;
        case (tgt)
            WB_TGT_RAM:  oh = 4'b0001;
            WB_TGT_REG:  oh = 4'b0010;
            WB_TGT_CRTC: oh = 4'b0100;
            WB_TGT_KBD:  oh = 4'b1000;
            default:     oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Target-ack watchdog: counts WAIT cycles and flags expiry after LIMIT cycles.
// Only present when WB_DECODE_TIMEOUT_EN is defined.
`ifdef WB_DECODE_TIMEOUT_EN
module wb_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count_q, count_d;

    // Expiry marks the LIMIT-th WAIT cycle; the error then appears on the following cycle.
    assign expired_o = en_i && (count_q == W'(LIMIT - 1));

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !expired_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) count_q <= '0;
        else         count_q <= count_d;
    end
endmodule
`endif

// File: rtl/wb_target_decoder.sv
// Wishbone responder-side decoder: routes one transaction at a time to RAM/REG/CRTC/KBD.
// Optional ack timeout is enabled by defining WB_DECODE_TIMEOUT_EN.
module wb_target_decoder
    import common_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TARGET_COUNT   = WB_TARGET_COUNT
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [19:0]               wb_adr_i,
    input  logic [7:0]                wb_dat_i,
    output logic [7:0]                wb_dat_o,
    input  logic                      wb_we_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    output logic                      wb_stall_o,
    output logic                      wb_ack_o,
    output logic                      wb_err_o,
    output logic [19:0]               tgt_adr_o,
    output logic [7:0]                tgt_dat_o,
    output logic                      tgt_we_o,
    output logic                      tgt_cyc_o,
    output logic [TARGET_COUNT-1:0]   tgt_stb_o,
    input  logic [8*TARGET_COUNT-1:0] tgt_dat_i,
    input  logic [TARGET_COUNT-1:0]   tgt_ack_i,
    output logic [19:0]               err_addr_o
);
    wb_state_t               state_q, state_d;
    logic [19:0]             adr_q, adr_d;
    logic [7:0]              dat_q, dat_d;
    logic                    we_q, we_d;
    logic [TARGET_COUNT-1:0] sel_q, sel_d;
    logic [TARGET_COUNT-1:0] stb_q, stb_d;
    logic                    cyc_q, cyc_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic                    stall_q, stall_d;
    logic [7:0]              rdata_q, rdata_d;
    logic [19:0]             err_addr_q, err_addr_d;

    wb_target_t              decoded;
    logic                    ack_sel;
    logic [7:0]              rbyte;
    logic                    timeout_hit;

    assign decoded = wb_decode(wb_adr_i);
    assign ack_sel = |(tgt_ack_i & sel_q);

    always_comb begin
        rbyte = '0;
        for (int i = 0; i < TARGET_COUNT; i++) begin
            if (sel_q[i]) rbyte = rbyte | tgt_dat_i[8*i +: 8];
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        we_d       = we_q;
        sel_d      = sel_q;
        stb_d      = '0;
        cyc_d      = cyc_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        stall_d    = 1'b0;
        rdata_d    = rdata_q;
        err_addr_d = err_addr_q;

        case (state_q)
            ST_IDLE: begin
                // stall_q still high here means an error is being returned this cycle.
                if (wb_cyc_i && wb_stb_i && !stall_q) begin
                    adr_d   = wb_adr_i;
                    dat_d   = wb_dat_i;
                    we_d    = wb_we_i;
                    sel_d   = wb_onehot(decoded);
                    stall_d = 1'b1;
                    if (decoded == WB_TGT_NONE) begin
                        err_d      = 1'b1;
                        err_addr_d = wb_adr_i;
                    end else begin
                        stb_d   = wb_onehot(decoded);
                        cyc_d   = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                stall_d = 1'b1;
                if (!wb_cyc_i) begin
                    cyc_d   = 1'b0;
                    stall_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (ack_sel) begin
                    cyc_d   = 1'b0;
                    ack_d   = 1'b1;
                    if (!we_q) rdata_d = rbyte;
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    cyc_d      = 1'b0;
                    err_d      = 1'b1;
                    err_addr_d = adr_q;
                    state_d    = ST_IDLE;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef WB_DECODE_TIMEOUT_EN
    logic wd_clr, wd_en;
    assign wd_clr = (state_q == ST_IDLE) && (state_d == ST_WAIT);
    assign wd_en  = (state_q == ST_WAIT);

    wb_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (timeout_hit)
    );
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            adr_q      <= '0;
            dat_q      <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            stb_q      <= '0;
            cyc_q      <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            stall_q    <= 1'b0;
            rdata_q    <= '0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            stb_q      <= stb_d;
            cyc_q      <= cyc_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            stall_q    <= stall_d;
            rdata_q    <= rdata_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign wb_dat_o   = rdata_q;
    assign wb_stall_o = stall_q;
    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;
    assign tgt_adr_o  = adr_q;
    assign tgt_dat_o  = dat_q;
    assign tgt_we_o   = we_q;
    assign tgt_cyc_o  = cyc_q;
    assign tgt_stb_o  = stb_q;
    assign err_addr_o = err_addr_q;
endmodule

// File: tb/tb_wb_target_decoder.sv
// Self-checking bench for wb_target_decoder: directed map/boundary cases plus random transactions
// compared against a transaction-level reference model.
module tb_wb_target_decoder;
    localparam int TO = 64;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [19:0] wb_adr_i = '0;
    logic [7:0]  wb_dat_i = '0;
    logic [7:0]  wb_dat_o;
    logic        wb_we_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_stall_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic [19:0] tgt_adr_o;
    logic [7:0]  tgt_dat_o;
    logic        tgt_we_o;
    logic        tgt_cyc_o;
    logic [3:0]  tgt_stb_o;
    logic [31:0] tgt_dat_i = '0;
    logic [3:0]  tgt_ack_i = '0;
    logic [19:0] err_addr_o;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_rdat = '0;
    logic [19:0] exp_err_addr = '0;

    wb_target_decoder #(.TIMEOUT_CYCLES(TO), .TARGET_COUNT(4)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_we_i    (wb_we_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_stall_o (wb_stall_o),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .tgt_adr_o  (tgt_adr_o),
        .tgt_dat_o  (tgt_dat_o),
        .tgt_we_o   (tgt_we_o),
        .tgt_cyc_o  (tgt_cyc_o),
        .tgt_stb_o  (tgt_stb_o),
        .tgt_dat_i  (tgt_dat_i),
        .tgt_ack_i  (tgt_ack_i),
        .err_addr_o (err_addr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Address map as 64 KiB page numbers: 0-1 RAM, 4 REG, 5 CRTC, 6-7 KBD, anything else unmapped.
    function automatic int ref_target(input logic [19:0] a);
        int page;
        page = int'(a) / 65536;
        if (page < 2)                return 0;
        if (page == 4)               return 1;
        if (page == 5)               return 2;
        if (page == 6 || page == 7)  return 3;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, wb_stall_o, 0);
        check({tag, "_ack"}, wb_ack_o, 0);
        check({tag, "_err"}, wb_err_o, 0);
        check({tag, "_dat_o"}, wb_dat_o, 0);
        check({tag, "_tadr"}, tgt_adr_o, 0);
        check({tag, "_tdat"}, tgt_dat_o, 0);
        check({tag, "_twe"}, tgt_we_o, 0);
        check({tag, "_tcyc"}, tgt_cyc_o, 0);
        check({tag, "_tstb"}, tgt_stb_o, 0);
        check({tag, "_erradr"}, err_addr_o, 0);
    endtask

    // One full transaction starting in the current cycle; targets ack 'lat' cycles after the strobe.
    task automatic run_txn(input logic [19:0] adr, input logic we, input logic [7:0] wd,
                           input int lat, input logic [7:0] rd, input logic [3:0] spur_or);
        int         tg;
        logic [3:0] oh;
        tg = ref_target(adr);
        wb_adr_i = adr; wb_we_i = we; wb_dat_i = wd;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; tgt_ack_i = '0;
        @(negedge clk_i);
        check("accept_stall", wb_stall_o, 0);
        step();
        wb_stb_i = 1'b0;
        wb_adr_i = 20'($urandom);
        wb_dat_i = 8'($urandom);
        if (tg < 0) begin
            wb_stb_i = 1'($urandom_range(0, 1));
            @(negedge clk_i);
            exp_err_addr = adr;
            check("unm_err", wb_err_o, 1);
            check("unm_ack", wb_ack_o, 0);
            check("unm_erradr", err_addr_o, exp_err_addr);
            check("unm_stb", tgt_stb_o, 0);
            check("unm_cyc", tgt_cyc_o, 0);
            check("unm_stall", wb_stall_o, 1);
            check("unm_dat_o", wb_dat_o, exp_rdat);
            step();
            wb_stb_i = 1'b0;
            @(negedge clk_i);
            check("unm_err_1cyc", wb_err_o, 0);
            check("unm_stall_rel", wb_stall_o, 0);
            check("unm_no_accept", tgt_stb_o, 0);
            step();
        end else begin
            oh = 4'b0001 << tg;
            for (int k = 1; k <= lat + 3; k++) begin
                tgt_dat_i = $urandom;
                tgt_ack_i = '0;
                if (k < lat + 1) tgt_ack_i = (4'($urandom) | spur_or) & ~oh;
                if (k == lat + 1) begin
                    tgt_ack_i = oh;
                    tgt_dat_i[8*tg +: 8] = rd;
                end
                wb_stb_i = (k <= lat + 2) ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clk_i);
                if (k == 1) begin
                    check("stb_onehot", tgt_stb_o, oh);
                    check("tgt_adr", tgt_adr_o, adr);
                    check("tgt_dat", tgt_dat_o, wd);
                    check("tgt_we", tgt_we_o, we);
                end else begin
                    check("stb_1cyc", tgt_stb_o, 0);
                end
                if (k <= lat + 1) begin
                    check("wait_stall", wb_stall_o, 1);
                    check("wait_cyc", tgt_cyc_o, 1);
                    check("wait_ack", wb_ack_o, 0);
                    check("wait_err", wb_err_o, 0);
                end else if (k == lat + 2) begin
                    if (!we) exp_rdat = rd;
                    check("resp_ack", wb_ack_o, 1);
                    check("resp_err", wb_err_o, 0);
                    check("resp_dat", wb_dat_o, exp_rdat);
                    check("resp_stall", wb_stall_o, 1);
                    check("resp_cyc", tgt_cyc_o, 0);
                end else begin
                    check("post_ack", wb_ack_o, 0);
                    check("post_stall", wb_stall_o, 0);
                    check("post_dat", wb_dat_o, exp_rdat);
                end
                step();
            end
        end
        wb_cyc_i = 1'b0;
        tgt_ack_i = '0;
    endtask

    task automatic run_abort();
        wb_adr_i = 20'h5000C; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        step();
        wb_stb_i = 1'b0;
        @(negedge clk_i);
        check("abt_stb", tgt_stb_o, 4'b0100);
        step();
        step();
        wb_cyc_i = 1'b0;
        @(negedge clk_i);
        check("abt_cyc_still", tgt_cyc_o, 1);
        step();
        tgt_ack_i = 4'b0100;
        tgt_dat_i = 32'h00EE0000;
        @(negedge clk_i);
        check("abt_cyc_drop", tgt_cyc_o, 0);
        check("abt_stall", wb_stall_o, 0);
        check("abt_ack", wb_ack_o, 0);
        check("abt_err", wb_err_o, 0);
        step();
        tgt_ack_i = '0;
        @(negedge clk_i);
        check("abt_late_ack", wb_ack_o, 0);
        check("abt_late_err", wb_err_o, 0);
        check("abt_dat_held", wb_dat_o, exp_rdat);
        step();
    endtask

    // KBD that never acks: error after TO WAIT cycles with the timeout, otherwise waits indefinitely.
    task automatic run_stuck();
        wb_adr_i = 20'h60009; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        step();
        wb_stb_i = 1'b0;
`ifdef WB_DECODE_TIMEOUT_EN
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk_i);
            check("to_wait_err", wb_err_o, 0);
            check("to_wait_stall", wb_stall_o, 1);
            step();
        end
        @(negedge clk_i);
        exp_err_addr = 20'h60009;
        check("to_err", wb_err_o, 1);
        check("to_ack", wb_ack_o, 0);
        check("to_erradr", err_addr_o, exp_err_addr);
        check("to_cyc", tgt_cyc_o, 0);
        check("to_stall", wb_stall_o, 1);
        step();
        @(negedge clk_i);
        check("to_err_1cyc", wb_err_o, 0);
        check("to_stall_rel", wb_stall_o, 0);
        step();
`else
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk_i);
            check("stuck_err", wb_err_o, 0);
            check("stuck_stall", wb_stall_o, 1);
            check("stuck_cyc", tgt_cyc_o, 1);
            step();
        end
        wb_cyc_i = 1'b0;
        step();
        @(negedge clk_i);
        check("stuck_drop_cyc", tgt_cyc_o, 0);
        check("stuck_drop_err", wb_err_o, 0);
        check("stuck_drop_stall", wb_stall_o, 0);
        step();
`endif
        wb_cyc_i = 1'b0;
    endtask

    initial begin
        #12;
        check_all_zero("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();

        run_txn(20'h40001, 1'b1, 8'hA5, 0, 8'h00, 4'b0000);
        run_txn(20'h5000C, 1'b0, 8'h00, 3, 8'h10, 4'b0000);
        run_txn(20'h08000, 1'b0, 8'h00, 2, 8'h3C, 4'b0100);
        run_txn(20'h60009, 1'b0, 8'h00, 1, 8'h7E, 4'b0000);
        run_txn(20'h80000, 1'b0, 8'h00, 0, 8'h00, 4'b0000);
        run_txn(20'h1FFFF, 1'b1, 8'h11, 1, 8'h00, 4'b0000);
        run_txn(20'h20000, 1'b0, 8'h00, 0, 8'h00, 4'b0000);
        run_txn(20'h3FFFF, 1'b1, 8'h22, 0, 8'h00, 4'b0000);
        run_txn(20'h7FFFF, 1'b0, 8'h00, 0, 8'hC3, 4'b0000);
        run_txn(20'hFFFFF, 1'b1, 8'h33, 0, 8'h00, 4'b0000);
        run_txn(20'h40002, 1'b0, 8'h00, TO - 1, 8'h5A, 4'b0000);

        for (int i = 0; i < 40; i++) begin
            run_txn(20'($urandom), 1'($urandom), 8'($urandom), $urandom_range(0, 5),
                    8'($urandom), 4'b0000);
        end

        run_abort();
        run_txn(20'h50001, 1'b0, 8'h00, 1, 8'h99, 4'b0000);
        run_stuck();
        run_txn(20'h40003, 1'b0, 8'h00, 2, 8'h4B, 4'b0000);

        wb_adr_i = 20'h60001; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        step();
        wb_stb_i = 1'b0;
        step();
        #2 rst_ni = 1'b0;
        #1;
        check_all_zero("midwait_reset");
        wb_cyc_i = 1'b0;
        exp_rdat = '0;
        exp_err_addr = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        run_txn(20'h40010, 1'b0, 8'h00, 1, 8'h6D, 4'b0000);
        run_txn(20'h90000, 1'b0, 8'h00, 0, 8'h00, 4'b0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
